// File: rtl/tlm_fifo_pkg.sv
// tlm_fifo_pkg: shared sizing helpers and the transaction word types carried
// by the FIFOs between stimulus source, reference model and sink.
package tlm_fifo_pkg;

  // Widths of the transaction words on each channel.
  localparam int STREAM_W  = 32;
  localparam int AMOSTRA_W = 32;

  // Default channel depth used by the source/model/sink instances.
  localparam int CHANNEL_DEPTH = 3;

  // source -> model channel word
  typedef logic [STREAM_W-1:0]  stream_t;
  // model -> sink channel word
  typedef logic [AMOSTRA_W-1:0] amostra_t;

  // Pointer width. At least one bit, even when a single entry needs none.
  function automatic int ptr_w(input int depth);
    int w;
    w = $clog2(depth);
    return (w < 1) ? 1 : w;
  endfunction

  // Occupancy counter width. It must be able to hold the value depth itself.
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/tlm_fifo_mem.sv
// tlm_fifo_mem: DEPTH x WIDTH register array. One synchronous write port,
// one combinational read port, so the head word falls through to the reader.
module tlm_fifo_mem
  import tlm_fifo_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 3
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [ptr_w(DEPTH)-1:0]  waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [ptr_w(DEPTH)-1:0]  raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Store the incoming word at the write address on an accepted put.
  // NOTE: the array has no reset; its contents are meaningless until written and the
  // pointers/count alone decide what is valid, so clearing it would only cost logic.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Combinational read of the entry the read pointer addresses.
  assign rdata = mem[raddr];

endmodule

// File: rtl/tlm_fifo.sv
// tlm_fifo: synchronous valid/ready FIFO between one producer (put side) and
// one consumer (get side). First-word fall-through, no same-cycle bypass;
// flags come from the registered count only.
//
// Optional build macro TLM_FIFO_STATUS_EN adds the status outputs:
//   used     - registered occupancy count
//   overflow - sticky, set when a put is offered while full, cleared by rst
module tlm_fifo
  import tlm_fifo_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     put_valid,
  output logic                     put_ready,
  input  logic [WIDTH-1:0]         put_data,
  output logic                     get_valid,
  input  logic                     get_ready,
  output logic [WIDTH-1:0]         get_data
`ifdef TLM_FIFO_STATUS_EN
  ,
  output logic [cnt_w(DEPTH)-1:0]  used,
  output logic                     overflow
`endif
);

  localparam int PW = ptr_w(DEPTH);
  localparam int CW = cnt_w(DEPTH);

  localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] count_next;
  logic          do_put;
  logic          do_get;

  // Pointer advance with explicit wrap, so DEPTH need not be a power of two.
  function automatic logic [PW-1:0] advance(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PW'(1);
  endfunction

  // Flags depend only on the registered count, never on this cycle's inputs.
  assign put_ready = (count != CNT_FULL);
  assign get_valid = (count != '0);

  // A transfer happens only when both sides of a handshake agree.
  assign do_put = put_valid & put_ready;
  assign do_get = get_valid & get_ready;

  // Next occupancy: +1 on put only, -1 on get only, unchanged otherwise.
  // NOTE: count_next is given a default before any branch so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    count_next = count;
    if (do_put && !do_get) begin
      count_next = count + CW'(1);
    end else if (!do_put && do_get) begin
      count_next = count - CW'(1);
    end
  end

  // Pointer and count registers; reset discards all stored words.
  // NOTE: non-blocking assignments keep every register sampling the pre-edge
  // values, so the pointers and count update together like real flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_put) begin
        wr_ptr <= advance(wr_ptr);
      end
      if (do_get) begin
        rd_ptr <= advance(rd_ptr);
      end
      count <= count_next;
    end
  end

  // Storage array: written at wr_ptr on a put, head read at rd_ptr.
  tlm_fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (do_put),
    .waddr (wr_ptr),
    .wdata (put_data),
    .raddr (rd_ptr),
    .rdata (get_data)
  );

`ifdef TLM_FIFO_STATUS_EN
  // Occupancy is exported directly from the registered count.
  assign used = count;

  // Sticky overflow: any put offered while full is remembered until reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (put_valid && !put_ready) begin
      overflow <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_tlm_fifo.sv
// tb_tlm_fifo: scoreboard bench for tlm_fifo (WIDTH=32, DEPTH=3). Accepted puts
// push the word into an expected queue; every get handshake pops and compares.
// Flags (and status outputs when TLM_FIFO_STATUS_EN is defined) are checked
// against the bench's own occupancy model every cycle.
module tb_tlm_fifo;

  localparam int WIDTH = 32;
  localparam int DEPTH = 3;

  logic             clk;
  logic             rst;
  logic             put_valid;
  logic             put_ready;
  logic [WIDTH-1:0] put_data;
  logic             get_valid;
  logic             get_ready;
  logic [WIDTH-1:0] get_data;
`ifdef TLM_FIFO_STATUS_EN
  logic [1:0]       used;
  logic             overflow;
`endif

  int vectors     = 0;
  int miscompares = 0;

  logic [WIDTH-1:0] exp_q[$];
  logic             exp_ovf;
  int               popped;

  tlm_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .put_valid (put_valid),
    .put_ready (put_ready),
    .put_data  (put_data),
    .get_valid (get_valid),
    .get_ready (get_ready),
    .get_data  (get_data)
`ifdef TLM_FIFO_STATUS_EN
    ,
    .used      (used),
    .overflow  (overflow)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Global time bound so the run can never hang.
  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, check outputs against the model mid-cycle,
  // then advance the model by the handshakes the model itself predicts.
  task automatic step(input logic pv, input logic [WIDTH-1:0] pd, input logic gr,
                      output logic put_acc, output logic get_acc);
    int sz;
    put_valid = pv;
    put_data  = pd;
    get_ready = gr;
    #1;
    sz = exp_q.size();
    check("put_ready", 64'(put_ready), 64'(sz != DEPTH));
    check("get_valid", 64'(get_valid), 64'(sz != 0));
    if (sz != 0) check("get_data", 64'(get_data), 64'(exp_q[0]));
`ifdef TLM_FIFO_STATUS_EN
    check("used", 64'(used), 64'(sz));
    check("overflow", 64'(overflow), 64'(exp_ovf));
`endif
    put_acc = pv && (sz != DEPTH);
    get_acc = gr && (sz != 0);
    @(posedge clk);
    #1;
    if (pv && (sz == DEPTH)) exp_ovf = 1'b1;
    if (get_acc) begin
      void'(exp_q.pop_front());
      popped++;
    end
    if (put_acc) exp_q.push_back(pd);
  endtask

  task automatic s(input logic pv, input logic [WIDTH-1:0] pd, input logic gr);
    logic pa, ga;
    step(pv, pd, gr, pa, ga);
  endtask

  // Reset for n cycles with a put and a get both offered; all of it is ignored.
  task automatic do_reset(input int n);
    rst       = 1'b1;
    put_valid = 1'b1;
    put_data  = 32'hDEAD_BEEF;
    get_ready = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    rst       = 1'b0;
    put_valid = 1'b0;
    get_ready = 1'b0;
    exp_q.delete();
    exp_ovf   = 1'b0;
  endtask

  initial begin
    logic pa, ga;
    int   next_word;
    int   cyc;

    rst       = 1'b1;
    put_valid = 1'b0;
    put_data  = '0;
    get_ready = 1'b0;
    exp_ovf   = 1'b0;
    popped    = 0;

    // Reset with put_valid held high: empty afterwards, nothing stored.
    do_reset(2);
    s(1'b0, '0, 1'b1);
    s(1'b0, '0, 1'b1);

    // Fill to full, attempt a fourth put, then drain in order.
    s(1'b1, 32'hA1, 1'b0);
    s(1'b1, 32'hA2, 1'b0);
    s(1'b1, 32'hA3, 1'b0);
    s(1'b1, 32'hA4, 1'b0);
    s(1'b0, '0, 1'b1);
    s(1'b0, '0, 1'b1);
    s(1'b0, '0, 1'b1);
    s(1'b0, '0, 1'b1);
    s(1'b0, '0, 1'b0);

    // Simultaneous put/get with one word stored.
    s(1'b1, 32'hB0, 1'b0);
    s(1'b1, 32'hB1, 1'b1);
    s(1'b0, '0, 1'b0);
    // Simultaneous put/get at full: get only, put retried next cycle.
    s(1'b1, 32'hB2, 1'b0);
    s(1'b1, 32'hB3, 1'b0);
    step(1'b1, 32'hB4, 1'b1, pa, ga);
    check("full_put_refused", 64'(pa), 64'd0);
    step(1'b1, 32'hB4, 1'b0, pa, ga);
    check("retry_put_taken", 64'(pa), 64'd1);
    repeat (4) s(1'b0, '0, 1'b1);

    // Wrap-around: stream 0..9 with alternating get_ready; hold each word until taken.
    do_reset(1);
    popped    = 0;
    next_word = 0;
    cyc       = 0;
    while (popped < 10 && cyc < 200) begin
      step(next_word < 10, 32'(next_word), cyc[0], pa, ga);
      if (pa) next_word++;
      cyc++;
    end
    check("wrap_words_out", 64'(popped), 64'd10);

    // Reset mid-operation discards both stored words.
    s(1'b1, 32'hC1, 1'b0);
    s(1'b1, 32'hC2, 1'b0);
    do_reset(1);
    s(1'b0, '0, 1'b1);
    s(1'b0, '0, 1'b1);
    s(1'b0, '0, 1'b1);

`ifdef TLM_FIFO_STATUS_EN
    // Status: three puts give used=3, an extra put sets sticky overflow.
    s(1'b1, 32'hD1, 1'b0);
    s(1'b1, 32'hD2, 1'b0);
    s(1'b1, 32'hD3, 1'b0);
    check("used_full", 64'(used), 64'd3);
    s(1'b1, 32'hD4, 1'b0);
    check("overflow_set", 64'(overflow), 64'd1);
    repeat (4) s(1'b0, '0, 1'b1);
    check("overflow_sticky", 64'(overflow), 64'd1);
    do_reset(1);
    #1;
    check("overflow_cleared", 64'(overflow), 64'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/tlm_fifo.md
Name: tlm_fifo

Overview:
- Synchronous first-in-first-out channel joining one producer (put side) and one consumer (get side).
- It is the RTL counterpart of the transaction FIFOs used between stimulus source, reference model and sink: source→model (stream) and model→sink (amostra), default depth 3.
- Transactions are opaque WIDTH-bit words.
- Valid/ready handshakes on both sides.

Parameters:
- WIDTH, 32, bits per transaction word.
- DEPTH, 3, number of storage entries; any integer ≥ 1, not required to be a power of two.

Ports:
- clk  input  1  single clock; all state changes on rising edge.
- rst  input  1  synchronous reset, active-high.
- put_valid  input  1  producer offers put_data this cycle.
- put_ready  output  1  FIFO can accept a word (not full).
- put_data  input  WIDTH  word to store.
- get_valid  output  1  FIFO holds at least one word (not empty).
- get_ready  input  1  consumer takes the head word this cycle.
- get_data  output  WIDTH  head (oldest) word; valid only when get_valid=1.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset response:
  - While rst=1 at a rising edge: read pointer, write pointer and count clear to 0.
  - put_ready=1, get_valid=0 after that edge.
  - Storage contents are not cleared; get_data is don't-care while empty.
- Reset mid-operation discards all stored words; any put or get in the reset cycle is ignored.
- Put: transfer occurs when put_valid & put_ready at the rising edge. The word is written at wr_ptr, then wr_ptr advances.
- Get: transfer occurs when get_valid & get_ready at the rising edge. rd_ptr advances.
- get_data: combinational read of mem[rd_ptr]; first-word fall-through.
- Latency: a word put into an empty FIFO appears on get_data/get_valid the cycle after the put edge. No same-cycle bypass.
- Status flags:
  - put_ready = (count != DEPTH).
  - get_valid = (count != 0).
  - Both are driven from registered count only; neither depends combinationally on put_valid or get_ready.
- Pointer wrap: a pointer equal to DEPTH-1 returns to 0 on advance. Explicit compare, no modulo-2^n.
- Pointer and count widths: pointers are $clog2(DEPTH) bits, minimum 1. count is $clog2(DEPTH+1) bits.
- Simultaneous put and get:
  - Non-empty, non-full: both occur and count is unchanged.
  - Full: only get occurs, since put_ready=0. A put succeeds next cycle.
  - Empty: only put occurs, since get_valid=0.
- Put when full (put_valid=1, put_ready=0): ignored, no state change. Producer must hold the word.
- Get when empty: ignored.
- Ordering: words leave in exactly the order accepted; no loss, no duplication.

Optional Feature:
- Macro: TLM_FIFO_STATUS_EN.
- When defined, adds output `used` ($clog2(DEPTH+1) bits), equal to registered count, reset to 0.
- When defined, adds sticky output `overflow` (1 bit). It is set on any edge where put_valid=1 and put_ready=0, and cleared only by rst.
- When undefined, neither port exists and the behaviour above is unchanged.

Decomposition:
- Package tlm_fifo_pkg:
  - function ptr_w(depth) returning max(1,$clog2(depth)).
  - function cnt_w(depth) returning $clog2(depth+1).
  - typedefs for the stream and amostra words, used by instances between source/model/sink.
- One natural sub-module, tlm_fifo_mem: DEPTH×WIDTH register array with one synchronous write port and one combinational read port.
- Pointer, count and flag logic stays in tlm_fifo.

Test Plan:
- Reset: assert rst 2 cycles with put_valid=1 → after release put_ready=1, get_valid=0, no word stored.
- Fill/drain (DEPTH=3):
  - put 0xA1, 0xA2, 0xA3 on consecutive cycles, get_ready=0 → put_ready=0 after third edge.
  - 4th put 0xA4 held → not stored.
  - Then drain → get_data 0xA1, 0xA2, 0xA3 in order, get_valid=0 after.
- Simultaneous:
  - With 1 word (0xB0) stored, put 0xB1 and get in the same cycle → get yields 0xB0, count stays 1, next get_data=0xB1.
  - Repeat at full: get occurs, put refused that cycle.
- Wrap-around: stream 10 words 0..9 with alternating get_ready → output sequence exactly 0..9, pointers wrap 2→0 correctly.
- Reset mid-operation: store 2 words, assert rst with put_valid and get_ready high → FIFO empty, neither word appears afterward.
- With TLM_FIFO_STATUS_EN:
  - 3 puts → used=3.
  - Extra put attempt → overflow=1, remaining 1 until rst.
